// File: rtl/tb_cmd_scheduler.sv
// Purpose : sequences one scenario command at a time onto the generic testbench targets
//           (set injector, check level, wait event, wait duration) and returns a status word.
// Latency : accept->rsp_valid is 2+ cycles for valid ops (1 cycle for BAD_OP); backpressure:
//           cmd_ready only in IDLE, response held until rsp_ready, no internal queueing.
// Ports   : cmd_* command handshake in; o_sel_*/o_start/o_abort/o_alias/o_data drive the targets;
//           i_*_done/i_check_ok completion from targets; rsp_* status handshake out;
//           err_count saturating count of non-OK responses, cleared by err_clr.
module tb_cmd_scheduler #(
    parameter int ALIAS_W = 5,
    parameter int DATA_W  = 32,
    parameter int TMO_W   = 16,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [ALIAS_W-1:0] cmd_alias,
    input  logic [DATA_W-1:0]  cmd_data,
    input  logic [TMO_W-1:0]   cmd_timeout,
    output logic               o_sel_set,
    output logic               o_sel_check,
    output logic               o_sel_wait_event,
    output logic               o_sel_wait_duration,
    output logic               o_start,
    output logic               o_abort,
    output logic [ALIAS_W-1:0] o_alias,
    output logic [DATA_W-1:0]  o_data,
    input  logic               i_set_done,
    input  logic               i_check_done,
    input  logic               i_wait_event_done,
    input  logic               i_wait_duration_done,
    input  logic               i_check_ok,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_status,
    output logic [ERR_W-1:0]   err_count,
    input  logic               err_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_SET           = 3'd0;
    localparam logic [2:0] OP_CHECK         = 3'd1;
    localparam logic [2:0] OP_WAIT_EVENT    = 3'd2;
    localparam logic [2:0] OP_WAIT_DURATION = 3'd3;

    localparam logic [1:0] ST_OK         = 2'd0;
    localparam logic [1:0] ST_CHECK_FAIL = 2'd1;
    localparam logic [1:0] ST_TIMEOUT    = 2'd2;
    localparam logic [1:0] ST_BAD_OP     = 2'd3;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [ALIAS_W-1:0] alias_q, alias_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [TMO_W-1:0]   timer_q, timer_d;
    logic [1:0]         status_q, status_d;
    logic               abort_q, abort_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               err_inc;
    logic               sel_done;
    logic               target_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            alias_q  <= '0;
            data_q   <= '0;
            tmo_q    <= '0;
            timer_q  <= '0;
            status_q <= ST_OK;
            abort_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            alias_q  <= alias_d;
            data_q   <= data_d;
            tmo_q    <= tmo_d;
            timer_q  <= timer_d;
            status_q <= status_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
        end
    end

    // Only the done of the target we actually selected may complete the command.
    always_comb begin
        sel_done = 1'b0;
        case (op_q)
            OP_SET:           sel_done = i_set_done;
            OP_CHECK:         sel_done = i_check_done;
            OP_WAIT_EVENT:    sel_done = i_wait_event_done;
            OP_WAIT_DURATION: sel_done = i_wait_duration_done;
            default:          sel_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        alias_d  = alias_q;
        data_d   = data_q;
        tmo_d    = tmo_q;
        timer_d  = timer_q;
        status_d = status_q;
        abort_d  = 1'b0;
        err_inc  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    alias_d = cmd_alias;
                    data_d  = cmd_data;
                    tmo_d   = cmd_timeout;
                    if (cmd_op > OP_WAIT_DURATION) begin
                        state_d  = S_RESP;
                        status_d = ST_BAD_OP;
                        err_inc  = 1'b1;
                    end else begin
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Done inputs are deliberately not looked at here: the target has
                // not seen o_start yet, so any done now belongs to something else.
                timer_d = tmo_q;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (sel_done) begin
                    // Done has priority over a timer expiring on the same edge.
                    state_d = S_RESP;
                    if (op_q == OP_CHECK && !i_check_ok) begin
                        status_d = ST_CHECK_FAIL;
                        err_inc  = 1'b1;
                    end else begin
                        status_d = ST_OK;
                    end
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TMO_W'(1);
                    if (timer_q == TMO_W'(1)) begin
                        state_d  = S_RESP;
                        status_d = ST_TIMEOUT;
                        abort_d  = 1'b1;
                        err_inc  = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear wins over a same-cycle failure; otherwise count up and stick at max.
        if (err_clr) begin
            err_d = '0;
        end else if (err_inc && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // op_q is always a legal op while a target is active, so a plain compare is one-hot.
    assign target_active       = (state_q == S_ISSUE) || (state_q == S_BUSY);
    assign o_sel_set           = target_active && (op_q == OP_SET);
    assign o_sel_check         = target_active && (op_q == OP_CHECK);
    assign o_sel_wait_event    = target_active && (op_q == OP_WAIT_EVENT);
    assign o_sel_wait_duration = target_active && (op_q == OP_WAIT_DURATION);
    assign o_start             = (state_q == S_ISSUE);
    assign o_abort             = abort_q;
    assign o_alias             = alias_q;
    assign o_data              = data_q;
    assign cmd_ready           = (state_q == S_IDLE);
    assign rsp_valid           = (state_q == S_RESP);
    assign rsp_status          = status_q;
    assign err_count           = err_q;

endmodule

// File: tb/tb_tb_cmd_scheduler.sv
// Purpose : self-checking bench for tb_cmd_scheduler: directed scenarios plus random commands
//           compared against a timing/status model of the command rules.
// Latency : n/a (bench); backpressure exercised by holding rsp_ready low for random spans.
module tb_tb_cmd_scheduler;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_CF  = 2'd1;
    localparam logic [1:0] ST_TMO = 2'd2;
    localparam logic [1:0] ST_BAD = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_alias;
    logic [31:0] cmd_data;
    logic [15:0] cmd_timeout;
    logic        o_sel_set, o_sel_check, o_sel_wait_event, o_sel_wait_duration;
    logic        o_start, o_abort;
    logic [4:0]  o_alias;
    logic [31:0] o_data;
    logic [3:0]  done_vec;
    logic        i_check_ok;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_status;
    logic [7:0]  err_count;
    logic        err_clr;
    logic [3:0]  sel_vec;

    int passed = 0;
    int total  = 0;
    int err_exp = 0;

    assign sel_vec = {o_sel_wait_duration, o_sel_wait_event, o_sel_check, o_sel_set};

    tb_cmd_scheduler dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_op               (cmd_op),
        .cmd_alias            (cmd_alias),
        .cmd_data             (cmd_data),
        .cmd_timeout          (cmd_timeout),
        .o_sel_set            (o_sel_set),
        .o_sel_check          (o_sel_check),
        .o_sel_wait_event     (o_sel_wait_event),
        .o_sel_wait_duration  (o_sel_wait_duration),
        .o_start              (o_start),
        .o_abort              (o_abort),
        .o_alias              (o_alias),
        .o_data               (o_data),
        .i_set_done           (done_vec[0]),
        .i_check_done         (done_vec[1]),
        .i_wait_event_done    (done_vec[2]),
        .i_wait_duration_done (done_vec[3]),
        .i_check_ok           (i_check_ok),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_status           (rsp_status),
        .err_count            (err_count),
        .err_clr              (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, observed no end, expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one command and follows it to the completed response handshake.
    // done_k: edge index (after the accept edge) at which the selected done is
    // sampled high; 0 means the target never finishes. Expectations come from the
    // command rules: done counts only from the second edge on and only inside the
    // timeout window; otherwise a nonzero timeout ends the command at edge T+1.
    task automatic run_cmd(input logic [2:0] op, input logic [4:0] al, input logic [31:0] dat,
                           input logic [15:0] tmo, input int done_k, input logic ok,
                           input bit noise, input int hold);
        int         j;
        bit         got;
        logic [1:0] exp_st;
        int         exp_edge;
        logic [3:0] exp_sel;
        if (op > 3'd3) begin
            exp_st   = ST_BAD;
            exp_edge = 0;
            exp_sel  = 4'b0000;
        end else begin
            exp_sel = 4'b0001 << op;
            if (done_k >= 2 && (tmo == 16'd0 || done_k <= int'(tmo) + 1)) begin
                exp_st   = (op == 3'd1 && !ok) ? ST_CF : ST_OK;
                exp_edge = done_k;
            end else begin
                exp_st   = ST_TMO;
                exp_edge = int'(tmo) + 1;
            end
        end

        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_alias   = al;
        cmd_data    = dat;
        cmd_timeout = tmo;
        tick();
        cmd_valid   = 1'b0;
        cmd_op      = 3'($urandom);
        cmd_alias   = 5'($urandom);
        cmd_data    = $urandom;
        cmd_timeout = 16'($urandom);

        j   = 0;
        got = 1'b0;
        while (!got && j < 200) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                check("o_start", 64'(o_start), 64'(j == 0));
                check("sel_busy", 64'(sel_vec), 64'(exp_sel));
                check("o_alias", 64'(o_alias), 64'(al));
                check("o_data", 64'(o_data), 64'(dat));
                check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
                done_vec   = noise ? (4'($urandom) & ~exp_sel) : 4'b0000;
                i_check_ok = 1'($urandom);
                if (j + 1 == done_k) begin
                    done_vec   = done_vec | exp_sel;
                    i_check_ok = ok;
                end
                tick();
                j++;
            end
        end
        done_vec = 4'b0000;

        check("rsp_seen", 64'(got), 64'd1);
        check("rsp_edge", 64'(j), 64'(exp_edge));
        check("rsp_status", 64'(rsp_status), 64'(exp_st));
        check("abort_first", 64'(o_abort), 64'(exp_st == ST_TMO));
        check("start_resp", 64'(o_start), 64'd0);
        check("sel_resp", 64'(sel_vec), 64'd0);
        if (exp_st != ST_OK && err_exp != 255) err_exp++;
        check("err_count", 64'(err_count), 64'(err_exp));
        check("cmd_ready_resp", 64'(cmd_ready), 64'd0);

        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            tick();
            check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            check("rsp_hold_status", 64'(rsp_status), 64'(exp_st));
            check("abort_hold", 64'(o_abort), 64'd0);
            check("cmd_ready_hold", 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_done_valid", 64'(rsp_valid), 64'd0);
        check("cmd_ready_after", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [15:0] r_tmo;
        int          r_k;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_alias   = 5'd0;
        cmd_data    = 32'd0;
        cmd_timeout = 16'd0;
        done_vec    = 4'b0000;
        i_check_ok  = 1'b0;
        rsp_ready   = 1'b0;
        err_clr     = 1'b0;

        // Reset state
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_sel", 64'(sel_vec), 64'd0);
        check("rst_start", 64'(o_start), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // SET with no timeout, done three cycles after the start pulse
        run_cmd(3'd0, 5'd2, 32'hCAFEDECA, 16'd0, 3, 1'b1, 1'b0, 0);
        // CHECK failing, then passing
        run_cmd(3'd1, 5'd1, 32'h0000_5678, 16'd0, 2, 1'b0, 1'b0, 0);
        run_cmd(3'd1, 5'd1, 32'h0000_5678, 16'd0, 2, 1'b1, 1'b0, 0);
        // WAIT_EVENT timeout 5: no done, then done on the expiry edge
        run_cmd(3'd2, 5'd4, 32'h0, 16'd5, 0, 1'b1, 1'b0, 1);
        run_cmd(3'd2, 5'd4, 32'h0, 16'd5, 6, 1'b1, 1'b0, 0);
        // Illegal op with the response held back for four cycles
        run_cmd(3'd5, 5'd9, 32'h1234, 16'd0, 0, 1'b1, 1'b0, 4);

        // WAIT_DURATION running, stray done on another target, then reset mid-BUSY
        check("wd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid   = 1'b1;
        cmd_op      = 3'd3;
        cmd_alias   = 5'd7;
        cmd_data    = 32'd100;
        cmd_timeout = 16'd0;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("wd_sel", 64'(sel_vec), 64'b1000);
            check("wd_no_rsp", 64'(rsp_valid), 64'd0);
            done_vec = 4'b0111;
            tick();
        end
        done_vec = 4'b0000;
        check("wd_still_busy", 64'(sel_vec), 64'b1000);
        check("wd_still_no_rsp", 64'(rsp_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", 64'(sel_vec), 64'd0);
        check("mid_rst_alias", 64'(o_alias), 64'd0);
        check("mid_rst_data", 64'(o_data), 64'd0);
        check("mid_rst_start_abort", 64'({o_start, o_abort}), 64'd0);
        check("mid_rst_rsp", 64'({rsp_valid, rsp_status}), 64'd0);
        check("mid_rst_err", 64'(err_count), 64'd0);
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        err_exp = 0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
            check("post_rst_ready", 64'(cmd_ready), 64'd1);
        end

        // Random commands against the model
        for (int n = 0; n < 80; n++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_tmo = 16'($urandom_range(0, 8));
            if (r_tmo == 16'd0) r_k = $urandom_range(2, 10);
            else                r_k = $urandom_range(0, int'(r_tmo) + 3);
            run_cmd(r_op, 5'($urandom), $urandom, r_tmo, r_k, 1'($urandom),
                    1'($urandom), $urandom_range(0, 2));
        end

        // Saturation of the error counter
        for (int n = 0; n < 258; n++) begin
            run_cmd(3'($urandom_range(4, 7)), 5'($urandom), $urandom, 16'd0, 0, 1'b1, 1'b0, 0);
        end
        check("err_saturated", 64'(err_count), 64'hFF);

        // Clear coinciding with a failing response entry
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        err_clr   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        err_exp   = 0;
        check("clr_status", 64'(rsp_status), 64'(ST_BAD));
        check("clr_err", 64'(err_count), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("clr_ready", 64'(cmd_ready), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tb_cmd_scheduler.md
# tb_cmd_scheduler

- Sequences testbench commands from the scenario sequencer onto the generic testbench modules: set injector, check level, wait event and wait duration.
- Accepts one command at a time over a valid/ready handshake, asserts one one-hot select, pulses a start, and waits for the selected module's done.
- Enforces an optional cycle timeout and returns a status word over a second valid/ready handshake.
- Sits between the sequencer and the testbench modules in tb_top.

## Interface
- ALIAS_W, 5: alias index width (up to 32 aliases per module)
- DATA_W, 32: command data width
- TMO_W, 16: timeout counter width
- ERR_W, 8: error counter width
- clk  in  1  testbench clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  scheduler can accept a command; equals (state==IDLE)
- cmd_op  in  3  0=SET, 1=CHECK, 2=WAIT_EVENT, 3=WAIT_DURATION, 4..7 invalid
- cmd_alias  in  ALIAS_W  target alias index
- cmd_data  in  DATA_W  value to set, value to check, or duration in cycles
- cmd_timeout  in  TMO_W  maximum BUSY cycles; 0 = no timeout
- o_sel_set, o_sel_check, o_sel_wait_event, o_sel_wait_duration  out  1 each  one-hot target select
- o_start  out  1  one-cycle start pulse to the selected target
- o_abort  out  1  one-cycle abort pulse to the selected target on timeout
- o_alias  out  ALIAS_W  latched alias
- o_data  out  DATA_W  latched data
- i_set_done, i_check_done, i_wait_event_done, i_wait_duration_done  in  1 each  target completion
- i_check_ok  in  1  check result; qualified by i_check_done
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_status  out  2  0=OK, 1=CHECK_FAIL, 2=TIMEOUT, 3=BAD_OP
- err_count  out  ERR_W  count of non-OK responses, saturating
- err_clr  in  1  synchronous clear of err_count

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESP.
- **IDLE**
  - On cmd_valid&cmd_ready, latch op, alias, data and timeout.
  - op>3: go to RESP with BAD_OP. No select, no start.
  - Otherwise go to ISSUE.
- **ISSUE** (exactly one cycle)
  - Selected o_sel_* = 1 and o_start = 1.
  - Timer loaded with the latched timeout.
  - Done inputs are ignored in this cycle.
  - Go to BUSY.
- **BUSY**
  - Select held; o_alias and o_data held stable.
  - Done of the selected target sampled high: go to RESP. Status is OK; for CHECK it is CHECK_FAIL if i_check_ok=0 at that edge.
  - Done inputs of non-selected targets are ignored.
  - Timer nonzero-enabled: decrement each BUSY cycle. If timer==1 at an edge with no selected done, go to RESP with TIMEOUT.
  - Done and expiry at the same edge: done wins.
- **RESP**
  - rsp_valid=1 and rsp_status held until rsp_ready.
  - All selects are 0.
  - o_abort=1 in the first RESP cycle only, and only for TIMEOUT.
  - On rsp_valid&rsp_ready, go to IDLE.
- **err_count**
  - Increments by 1 on each entry into RESP with status≠OK.
  - Saturates at 2^ERR_W-1.
  - err_clr has priority over an increment in the same cycle.
- **Reset**
  - Reset at any time, including mid-command, forces IDLE.
  - All registered outputs go to 0: selects, o_start, o_abort, o_alias, o_data, rsp_valid, rsp_status, err_count, timer.
  - cmd_ready reads 1 during and after reset (IDLE decode).
  - A pending command is dropped; no response is produced.

## Timing
- Accept edge = E0. ISSUE occupies cycle E0..E1, with o_start high for that cycle. BUSY starts at E1.
- Done sampled at edge Ek (k≥2) gives rsp_valid from Ek. Minimum accept-to-rsp_valid is 2 cycles; BAD_OP is 1 cycle.
- Timeout T≥1 allows done at edges E2..E(T+1). With no done, TIMEOUT rsp_valid rises at E(T+1).
- Back-to-back: the response handshake at edge Er gives cmd_ready=1 from Er. The next command can be accepted at E(r+1).
- All outputs are registered or state-decoded. No combinational path from inputs to outputs.

## Test plan
- SET alias 2, data 0xCAFEDECA, timeout 0; i_set_done 3 cycles after o_start → o_sel_set one-hot, o_alias=2, o_data=0xCAFEDECA, status OK, err_count 0.
- CHECK alias 1, data 0x5678; i_check_done with i_check_ok=0 → CHECK_FAIL, err_count=1. Repeat with ok=1 → OK, err_count stays 1.
- WAIT_EVENT timeout 5; no done → TIMEOUT with rsp_valid at E6, o_abort one pulse, err_count++. Repeat with done at exactly E6 → OK (done wins).
- op=5 → BAD_OP 1 cycle after accept, no select and no o_start. Hold rsp_ready=0 for 4 cycles → rsp_valid and status stable, cmd_ready=0.
- WAIT_DURATION active; pulse i_set_done (non-selected) → ignored. Assert rst_n=0 mid-BUSY → all outputs 0 immediately, cmd_ready=1, no response after release.
- Force 2^ERR_W+2 BAD_OP commands → err_count saturates at 0xFF. err_clr concurrent with a failure → err_count=0.
